dma_priority_arbiter: RTL and testbench
=======================================

# dma_priority_arbiter

Channel arbiter and bus-hold sequencer for the 8237A-style DMA controller. Combines hardware DREQ lines with software requests and applies masks and command-register policy. Runs the HRQ/HLDA handshake with the CPU, then grants exactly one channel to the transfer FSM until that FSM reports service complete. Sits between `dmaRegIf.PRIORITY` (command/request/mask) and the transfer FSM.

## Interface
Parameters:
- `NUM_CH`, 4, channel count; power of two; only 4 is supported.

Ports:
- `CLK`  in  1  system clock; all state on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `DREQ`  in  NUM_CH  raw hardware requests, already synchronized upstream.
- `commandReg`  in  8  bit2 controller disable, bit4 rotating priority, bit6 DREQ active-low, bit7 DACK active-high.
- `requestReg`  in  8  bits[3:0] software requests.
- `maskReg`  in  8  bits[3:0] channel masks; 1 = masked.
- `HLDA`  in  1  CPU hold acknowledge.
- `svcDone`  in  1  one-cycle pulse from the FSM: the granted channel's service is finished.
- `HRQ`  out  1  hold request to the CPU.
- `DACK`  out  NUM_CH  per-channel acknowledge; polarity set by commandReg bit7.
- `grantValid`  out  1  a channel is granted to the FSM.
- `grantCh`  out  $clog2(NUM_CH)  index of the granted channel.

## Operation
- Effective request: `req = ((commandReg[6] ? ~DREQ : DREQ) | requestReg[3:0]) & ~maskReg[3:0]`. When commandReg[2]=1, `req` is forced to 0.
- State machine `ARB_IDLE → ARB_HOLD_REQ → ARB_ACTIVE → ARB_RELEASE → ARB_IDLE`.
- `ARB_IDLE`: HRQ=0. If any `req` bit is set, go to HOLD_REQ.
- `ARB_HOLD_REQ`: HRQ=1.
  - If HLDA=1, pick the winner from the current `req`, register it into `grantCh`, and go to ACTIVE.
  - If `req` drops to 0 before HLDA arrives, return to IDLE.
- `ARB_ACTIVE`: HRQ=1, grantValid=1, DACK asserted for `grantCh` only.
  - No preemption: higher-priority requests are ignored. Mask and disable changes do not revoke an active grant.
  - `svcDone` → RELEASE.
  - HLDA=0 without `svcDone` → IDLE (abort), with no rotation update.
  - `svcDone` and HLDA falling in the same cycle count as completion.
- `ARB_RELEASE`: HRQ=0, grantValid=0, DACK inactive. If rotating priority is enabled, `lowPri <= grantCh`. Go to IDLE.
- Priority:
  - Fixed mode: ch0 highest, ch3 lowest.
  - Rotating mode: the highest-priority channel is `(lowPri+1) mod NUM_CH`, descending with wrap-around.
- DACK is driven as `commandReg[7] ? dackHot : ~dackHot`, where `dackHot` is a registered one-hot vector.

## Timing
- Reset values:
  - state=ARB_IDLE, HRQ=0, grantValid=0, grantCh=0, dackHot=0, lowPri=NUM_CH-1.
  - DACK = 4'hF while commandReg=0.
- Reset mid-service drops HRQ, grantValid and DACK on the next edge, with no handshake.
- `req` nonzero at edge N → HRQ=1 after edge N.
- HLDA=1 sampled at edge M in HOLD_REQ → grantValid, grantCh and DACK valid after edge M. `grantCh` is stable for the whole grant.
- `svcDone` at edge K → after edge K, grantValid=0, DACK inactive and HRQ=0 for exactly one cycle. IDLE after K+1. The earliest re-arbitration raises HRQ after K+2.
- `commandReg[7]` is applied combinationally to DACK. A polarity change takes effect the same cycle.
- `svcDone` outside ACTIVE is ignored.

## Configuration
- `DMA_ROTATE_PRIORITY_EN` defined: commandReg[4] selects rotating (1) or fixed (0) priority, and the `lowPri` register exists.
- Not defined: fixed priority always, commandReg[4] is ignored, and `lowPri` is removed (constant NUM_CH-1).

## Structure
- Shared package `dma_pkg` holds:
  - enum `arb_state_t` {ARB_IDLE, ARB_HOLD_REQ, ARB_ACTIVE, ARB_RELEASE}
  - `DMA_NUM_CH=4`
  - command bit positions `CMD_DISABLE=2`, `CMD_ROTATE=4`, `CMD_DREQ_LOW=6`, `CMD_DACK_HIGH=7`
- One sub-module, `dma_prio_encoder`: combinational. Takes `req` and `lowPri`/mode; returns `winner` and `any`. Implements rotate, pick-first and un-rotate.

## Test plan
- Fixed priority: commandReg=0, DREQ=4'b1010, HLDA pulled high one cycle after HRQ → grantCh=1, DACK=4'b1101; `svcDone` → next grant is ch3.
- Rotating priority: commandReg=8'h10, all DREQ high, 4 consecutive services → grants 0,1,2,3, then 0 again (wrap).
- Mask, software request and sense: maskReg=4'h1, DREQ=4'h1 → HRQ stays 0. Then requestReg=4'h4 → grantCh=2. With commandReg[6]=1 and DREQ=4'hE → ch0 requests.
- Abort and disable: HLDA drops mid-ACTIVE → IDLE next cycle, `lowPri` unchanged. commandReg[2]=1 in HOLD_REQ → HRQ=0 next cycle.
- Boundaries: `req` withdrawn before HLDA → back to IDLE with no DACK. RESET during ACTIVE → all outputs at reset values next cycle.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and command-register bit positions for the 8237A-style DMA controller.
package dma_pkg;

  localparam int DMA_NUM_CH    = 4;

  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HOLD_REQ,
    ARB_ACTIVE,
    ARB_RELEASE
  } arb_state_t;

endpackage

// File: rtl/dma_prio_encoder.sv
// Combinational channel priority encoder: rotate so the top-priority channel is scanned
// first, pick the first set request, then map the scan position back to a channel index.
module dma_prio_encoder
  import dma_pkg::*;
#(
  parameter int  NUM_CH = DMA_NUM_CH,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     low_pri,
  input  logic              rotate_en,
  output logic [CW-1:0]     winner,
  output logic              any
);

  logic [CW-1:0] base;
  logic [CW-1:0] idx;
  logic          found;

  // Index arithmetic wraps modulo NUM_CH because NUM_CH is a power of two.
  always_comb begin
    base   = rotate_en ? (low_pri + CW'(1)) : '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = base + CW'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter and HRQ/HLDA bus-hold sequencer; grants one channel until svcDone.
// Optional rotating priority is built only when DMA_ROTATE_PRIORITY_EN is defined.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int  NUM_CH = DMA_NUM_CH,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [7:0]        commandReg,
  input  logic [7:0]        requestReg,
  input  logic [7:0]        maskReg,
  input  logic              HLDA,
  input  logic              svcDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CW-1:0]     grantCh
);

  arb_state_t        state_q;
  logic              hrq_q;
  logic              grant_vld_q;
  logic [CW-1:0]     grant_ch_q;
  logic [NUM_CH-1:0] dack_hot_q;

  logic [NUM_CH-1:0] dreq_act;
  logic [NUM_CH-1:0] req;
  logic [CW-1:0]     low_pri;
  logic [CW-1:0]     winner;
  logic              rotate_en;
  logic              req_any;

  assign dreq_act = commandReg[CMD_DREQ_LOW] ? ~DREQ : DREQ;
  assign req      = commandReg[CMD_DISABLE] ? '0
                  : ((dreq_act | requestReg[NUM_CH-1:0]) & ~maskReg[NUM_CH-1:0]);

`ifdef DMA_ROTATE_PRIORITY_EN
  logic [CW-1:0] low_pri_q;
  logic          unused_bits;
  assign low_pri     = low_pri_q;
  assign rotate_en   = commandReg[CMD_ROTATE];
  assign unused_bits = ^{commandReg[5], commandReg[3], commandReg[1:0],
                         requestReg[7:NUM_CH], maskReg[7:NUM_CH]};
`else
  logic          unused_bits;
  assign low_pri     = CW'(NUM_CH - 1);
  assign rotate_en   = 1'b0;
  assign unused_bits = ^{commandReg[5:3], commandReg[1:0],
                         requestReg[7:NUM_CH], maskReg[7:NUM_CH]};
`endif

  dma_prio_encoder #(
    .NUM_CH (NUM_CH)
  ) u_enc (
    .req       (req),
    .low_pri   (low_pri),
    .rotate_en (rotate_en),
    .winner    (winner),
    .any       (req_any)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ARB_IDLE;
      hrq_q       <= 1'b0;
      grant_vld_q <= 1'b0;
      grant_ch_q  <= '0;
      dack_hot_q  <= '0;
`ifdef DMA_ROTATE_PRIORITY_EN
      low_pri_q   <= CW'(NUM_CH - 1);
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (req_any) begin
            state_q <= ARB_HOLD_REQ;
            hrq_q   <= 1'b1;
          end
        end
        ARB_HOLD_REQ: begin
          // A withdrawn request wins over a late HLDA: nothing left to serve.
          if (!req_any) begin
            state_q <= ARB_IDLE;
            hrq_q   <= 1'b0;
          end else if (HLDA) begin
            state_q     <= ARB_ACTIVE;
            grant_vld_q <= 1'b1;
            grant_ch_q  <= winner;
            dack_hot_q  <= NUM_CH'(1) << winner;
          end
        end
        ARB_ACTIVE: begin
          // svcDone takes precedence so a simultaneous HLDA drop still counts as completion.
          if (svcDone) begin
            state_q     <= ARB_RELEASE;
            hrq_q       <= 1'b0;
            grant_vld_q <= 1'b0;
            dack_hot_q  <= '0;
          end else if (!HLDA) begin
            state_q     <= ARB_IDLE;
            hrq_q       <= 1'b0;
            grant_vld_q <= 1'b0;
            dack_hot_q  <= '0;
          end
        end
        ARB_RELEASE: begin
          state_q <= ARB_IDLE;
`ifdef DMA_ROTATE_PRIORITY_EN
          if (rotate_en) begin
            low_pri_q <= grant_ch_q;
          end
`endif
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign HRQ        = hrq_q;
  assign grantValid = grant_vld_q;
  assign grantCh    = grant_ch_q;
  assign DACK       = commandReg[CMD_DACK_HIGH] ? dack_hot_q : ~dack_hot_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: table of single-grant transactions plus
// hand-written abort, withdraw, disable, polarity and reset sequences.
module tb_dma_priority_arbiter;

`ifdef DMA_ROTATE_PRIORITY_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       CLK        = 1'b0;
  logic       RESET      = 1'b1;
  logic [3:0] DREQ       = 4'h0;
  logic [7:0] commandReg = 8'h00;
  logic [7:0] requestReg = 8'h00;
  logic [7:0] maskReg    = 8'h00;
  logic       HLDA       = 1'b0;
  logic       svcDone    = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantCh;

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DREQ       (DREQ),
    .commandReg (commandReg),
    .requestReg (requestReg),
    .maskReg    (maskReg),
    .HLDA       (HLDA),
    .svcDone    (svcDone),
    .HRQ        (HRQ),
    .DACK       (DACK),
    .grantValid (grantValid),
    .grantCh    (grantCh)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] cmd;
    logic [3:0] dreq;
    logic [3:0] rreq;
    logic [3:0] mask;
    logic [1:0] exp_ch;
    logic [3:0] exp_dack;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [3:0] dack;
  } grant_t;

  grant_t sb_q[$];
  vec_t   vecs[13];
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic logic [3:0] oh(input logic [1:0] c);
    oh = 4'b0001 << c;
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    commandReg = 8'h00;
    DREQ       = 4'h0;
    requestReg = 8'h00;
    maskReg    = 8'h00;
  endtask

  // Raise HLDA from HOLD_REQ; the grant must be visible after the very next edge.
  task automatic grant(input string name, input logic [1:0] ch, input logic [3:0] dack);
    grant_t g;
    grant_t got;
    g.ch   = ch;
    g.dack = dack;
    sb_q.push_back(g);
    HLDA = 1'b1;
    tick();
    check({name, "_vld"}, grantValid, 1);
    check({name, "_hrq"}, HRQ, 1);
    if (grantValid === 1'b1) begin
      got = sb_q.pop_front();
      check({name, "_ch"}, grantCh, got.ch);
      check({name, "_dack"}, DACK, got.dack);
    end
  endtask

  // Pulse svcDone; one RELEASE cycle with everything dropped, then IDLE with HRQ still low.
  task automatic service(input string name);
    logic [3:0] idle_dack;
    idle_dack = commandReg[7] ? 4'h0 : 4'hF;
    svcDone = 1'b1;
    tick();
    svcDone = 1'b0;
    HLDA    = 1'b0;
    check({name, "_vld"}, grantValid, 0);
    check({name, "_hrq"}, HRQ, 0);
    check({name, "_dack"}, DACK, idle_dack);
    tick();
    check({name, "_hrq_k1"}, HRQ, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] e;

    vecs[0] = '{8'h00, 4'b1010, 4'h0, 4'h0, 2'd1, 4'b1101};
    vecs[1] = '{8'h00, 4'b1000, 4'h0, 4'h0, 2'd3, 4'b0111};
    vecs[2] = '{8'h80, 4'b0100, 4'h0, 4'h0, 2'd2, 4'b0100};
    vecs[3] = '{8'h00, 4'b0001, 4'h4, 4'h1, 2'd2, 4'b1011};
    vecs[4] = '{8'h40, 4'b1110, 4'h0, 4'h0, 2'd0, 4'b1110};
    vecs[5] = '{8'h00, 4'b0000, 4'h8, 4'h0, 2'd3, 4'b0111};
    vecs[6] = '{8'h00, 4'b1111, 4'h0, 4'h3, 2'd2, 4'b1011};
    vecs[7] = '{8'hC0, 4'b0111, 4'h0, 4'h0, 2'd3, 4'b1000};
    for (int k = 0; k < 5; k++) begin
      e = ROT ? 2'(k) : 2'd0;
      vecs[8 + k] = '{8'h10, 4'hF, 4'h0, 4'h0, e, ~oh(e)};
    end

    tick();
    tick();
    check("rst_hrq", HRQ, 0);
    check("rst_vld", grantValid, 0);
    check("rst_ch", grantCh, 0);
    check("rst_dack", DACK, 4'hF);
    RESET = 1'b0;
    tick();
    check("idle_hrq", HRQ, 0);

    for (int i = 0; i < 13; i++) begin
      commandReg = vecs[i].cmd;
      DREQ       = vecs[i].dreq;
      requestReg = {4'h0, vecs[i].rreq};
      maskReg    = {4'h0, vecs[i].mask};
      tick();
      check($sformatf("v%0d_hrq", i), HRQ, 1);
      grant($sformatf("v%0d", i), vecs[i].exp_ch, vecs[i].exp_dack);
      service($sformatf("v%0d_rel", i));
    end
    clear_inputs();
    tick();

    // Masked hardware request never raises HRQ.
    maskReg = 8'h01;
    DREQ    = 4'h1;
    tick();
    tick();
    tick();
    check("mask_hrq", HRQ, 0);
    clear_inputs();
    tick();

    // Request withdrawn before HLDA: back to IDLE, no DACK, late HLDA ignored.
    DREQ = 4'b0100;
    tick();
    check("wd_hrq_up", HRQ, 1);
    DREQ = 4'h0;
    tick();
    check("wd_hrq_down", HRQ, 0);
    check("wd_dack", DACK, 4'hF);
    HLDA = 1'b1;
    tick();
    check("wd_late_hlda_vld", grantValid, 0);
    check("wd_late_hlda_hrq", HRQ, 0);
    HLDA = 1'b0;

    // Controller disable while waiting for HLDA.
    DREQ = 4'h1;
    tick();
    check("dis_hrq_up", HRQ, 1);
    commandReg = 8'h04;
    tick();
    check("dis_hrq_down", HRQ, 0);
    clear_inputs();
    tick();

    // Abort by HLDA drop leaves the rotation pointer untouched.
    commandReg = 8'h10;
    DREQ       = 4'hF;
    tick();
    check("ab_hrq", HRQ, 1);
    e = ROT ? 2'd1 : 2'd0;
    grant("ab_pre", e, ~oh(e));
    HLDA = 1'b0;
    tick();
    check("ab_vld", grantValid, 0);
    check("ab_hrq_down", HRQ, 0);
    tick();
    check("ab_rearb_hrq", HRQ, 1);
    grant("ab_post", e, ~oh(e));

    // svcDone with simultaneous HLDA drop is a completion, not an abort.
    svcDone = 1'b1;
    HLDA    = 1'b0;
    tick();
    svcDone = 1'b0;
    check("sim_vld", grantValid, 0);
    check("sim_hrq", HRQ, 0);
    tick();
    check("sim_hrq_k1", HRQ, 0);
    tick();
    check("sim_hrq_k2", HRQ, 1);

    // svcDone outside ACTIVE does nothing; the following grant sees the rotated pointer.
    svcDone = 1'b1;
    tick();
    svcDone = 1'b0;
    check("stray_svc_hrq", HRQ, 1);
    check("stray_svc_vld", grantValid, 0);
    e = ROT ? 2'd2 : 2'd0;
    grant("after_sim", e, ~oh(e));

    // DACK polarity follows commandReg[7] within the same cycle.
    commandReg = 8'h90;
    #1;
    check("pol_dack", DACK, oh(e));

    // Reset mid-service.
    RESET = 1'b1;
    tick();
    check("mid_rst_hrq", HRQ, 0);
    check("mid_rst_vld", grantValid, 0);
    check("mid_rst_ch", grantCh, 0);
    check("mid_rst_dack", DACK, 4'h0);
    RESET      = 1'b0;
    HLDA       = 1'b0;
    commandReg = 8'h10;
    DREQ       = 4'hF;
    tick();
    check("post_rst_hrq", HRQ, 1);
    grant("post_rst", 2'd0, 4'b1110);
    service("post_rst_rel");
    clear_inputs();
    tick();

    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
